// File: rtl/std_sram_arb_pkg.sv
// std_sram_arb_pkg: shared port ids and response-pipeline entry type for the two-port SRAM arbiter
package std_sram_arb_pkg;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    typedef struct packed {
        logic valid;
        logic port_id;
    } rsp_entry_t;
endpackage

// File: rtl/std_sram_rsp_tracker.sv
// std_sram_rsp_tracker: latency-matched {valid, port_id} shift pipeline with synchronous active-low clear
module std_sram_rsp_tracker
    import std_sram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       regrstn,
    input  rsp_entry_t push,
    output rsp_entry_t last
);
    rsp_entry_t [DEPTH-1:0] pipe;
    always_ff @(posedge clk) begin
        pipe[0] <= regrstn ? push : '0;
        for (int i = 1; i < DEPTH; i++) pipe[i] <= regrstn ? pipe[i-1] : '0;
    end
    assign last = pipe[DEPTH-1];
endmodule

// File: rtl/std_sram_singleport_arb2.sv
// std_sram_singleport_arb2: round-robin arbiter sharing one registered-output single-port SRAM between two clients
module std_sram_singleport_arb2
    import std_sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  regrstn,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);
    logic       v0, v1, g0, g1, prio;
    rsp_entry_t push, last;
    always_comb begin
        v0 = p0_req_valid & regrstn;
        v1 = p1_req_valid & regrstn;
        g1 = v1 & (!v0 | prio == PORT1);
        g0 = v0 & !g1;
        p0_req_ready = g0;
        p1_req_ready = g1;
        sram_en = v0 | v1;
        sram_we = g0 ? p0_req_we : g1 ? p1_req_we : 1'b0;
        sram_addr = g0 ? p0_req_addr : g1 ? p1_req_addr : '0;
        sram_din = g0 ? p0_req_wdata : g1 ? p1_req_wdata : '0;
        push.valid = (g0 | g1) & !sram_we;
        push.port_id = g1 ? PORT1 : PORT0;
        p0_rsp_valid = regrstn & last.valid & last.port_id == PORT0;
        p1_rsp_valid = regrstn & last.valid & last.port_id == PORT1;
        p0_rsp_rdata = sram_dout;
        p1_rsp_rdata = sram_dout;
    end
    always_ff @(posedge clk)
        prio <= !regrstn ? PORT0 : g0 ? PORT1 : g1 ? PORT0 : prio;
    std_sram_rsp_tracker #(.DEPTH(READ_LATENCY)) u_trk (
        .clk(clk),
        .regrstn(regrstn),
        .push(push),
        .last(last)
    );
endmodule
